scroll_addr_gen: RTL
====================

// Module: scroll_addr_gen
// PURPOSE
//  Parametrised frame-buffer address generator for the VGA image path; it sits between vga_controller
//  (h_cnt/v_cnt/valid) and the block-RAM read port. Maps 640x480 screen coordinates onto an IMG_W x IMG_H
//  stored image, with: independent X/Y scroll offsets advanced by a tick, h/v mirroring, 2x centred
//  enlarge, and frame-synchronous latching of all mode controls (no tearing). Registered output.
// PARAMETERS
//  IMG_W        320  stored image width in pixels
//  IMG_H        240  stored image height in pixels
//  SCALE_SHIFT  1    base downscale: image coord = screen coord >> SCALE_SHIFT
//  ADDR_W       17   pixel_addr width; must hold IMG_W*IMG_H-1
//  STEP         1    offset change per accepted tick; 1 <= STEP < min(IMG_W,IMG_H)
// PORTS
//  clk         in   1       pixel clock (25 MHz)
//  rst         in   1       asynchronous, active-low reset (0 = reset)
//  tick        in   1       single-cycle scroll-advance strobe (e.g. from clock_divider), sync to clk
//  en          in   1       1 = scrolling enabled
//  dir         in   1       0 = offsets increase, 1 = offsets decrease
//  mode        in   2       scroll axis: 00 none, 01 vertical, 10 horizontal, 11 diagonal
//  hmir        in   1       horizontal mirror
//  vmir        in   1       vertical mirror
//  enlarge     in   1       extra 2x zoom on the image centre
//  h_cnt       in   10      screen column from vga_controller
//  v_cnt       in   10      screen row from vga_controller
//  valid       in   1       visible-area flag from vga_controller
//  pixel_addr  out  ADDR_W  RAM read address (registered)
//  pixel_ok    out  1       pixel_addr is valid and in-image (registered)
//  wrap        out  1       1-cycle pulse when either offset wraps (or bounces)
// BEHAVIOUR
//  Reset (rst=0, async): x_off=0, y_off=0, shadow controls = 0, pixel_addr=0, pixel_ok=0, wrap=0.
//  Shadow regs: mode/hmir/vmir/enlarge are copied into shadows only in the cycle where
//   h_cnt==0 && v_cnt==0; all address maths uses the shadows. en/dir are used live.
//  Offset update, on the clock edge with tick=1 && en=1:
//   axis X active if mode[1], Y active if mode[0]; inactive axis holds.
//   dir=0: off = off+STEP; if result >= LIMIT then off -= LIMIT (LIMIT = IMG_W for X, IMG_H for Y).
//   dir=1: off = off-STEP; if off < STEP then off += LIMIT-STEP. Offsets are always in [0, LIMIT-1].
//   wrap=1 for exactly the cycle after any active-axis wrap; tick with en=0 or mode=00 changes nothing.
//   Concurrent frame-start latch and tick: both take effect; the tick uses the pre-latch mode.
//  Address path (combinational part, then one register stage; latency 1 clk):
//   sx = h_cnt >> SCALE_SHIFT, sy = v_cnt >> SCALE_SHIFT;
//   enlarge: sx = (h_cnt >> (SCALE_SHIFT+1)) + IMG_W/4, sy = (v_cnt >> (SCALE_SHIFT+1)) + IMG_H/4.
//   in = valid && sx < IMG_W && sy < IMG_H (checked before mirroring).
//   hmir: sx = IMG_W-1-sx; vmir: sy = IMG_H-1-sy.
//   u = sx + x_off, minus IMG_W if >= IMG_W; w = sy + y_off, minus IMG_H if >= IMG_H.
//   next pixel_addr = in ? w*IMG_W + u : 0; next pixel_ok = in. No modulo operator.
//  All intermediates wide enough that no truncation occurs before the final ADDR_W assignment.
// CONFIGURATION
//  BOUNCE_EN defined: an active-axis offset reverses instead of wrapping. Internal per-axis
//   direction flag, reset 0, XOR-ed with dir. Increasing past LIMIT-1: off = LIMIT-1, flag toggles;
//   decreasing below 0: off = 0, flag toggles. wrap pulses on every reversal.
//  BOUNCE_EN undefined: modular wrap as above; no direction flags exist.
// TESTING
//  1 rst=0 mid-frame with tick pulsing -> next edge: pixel_addr=0, pixel_ok=0, offsets 0; held while rst=0.
//  2 defaults, mode=00, h_cnt=10,v_cnt=6,valid=1 -> pixel_addr=3*320+5=965 one clk later, pixel_ok=1.
//  3 mode=01, dir=0, 239 ticks then 1 more -> y_off 239 then 0, wrap=1 single cycle;
//    with BOUNCE_EN: y_off stays 239, then 238 on following tick.
//  4 hmir toggled mid-frame -> addressing changes only after h_cnt=0,v_cnt=0; then h_cnt=0,v_cnt=0
//    -> pixel_addr=319.
//  5 enlarge=1, h_cnt=0,v_cnt=0 -> pixel_addr=60*320+80=19280; h_cnt=639,v_cnt=479 -> 179*320+239.
//  6 valid=0 or sx>=IMG_W (IMG_W=256, h_cnt=600) -> pixel_ok=0, pixel_addr=0.

Source files
------------

// File: rtl/scroll_addr_gen.sv
// scroll_addr_gen: maps 640x480 VGA screen coordinates onto an IMG_W x IMG_H
// stored image with X/Y scrolling, h/v mirroring and a 2x centred enlarge.
// Mode controls are latched at frame start so a frame never tears.
// Optional feature: define BOUNCE_EN to make offsets reverse at the image
// edges instead of wrapping around.
`timescale 1ns/1ps
module scroll_addr_gen #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int STEP        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              en,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic              hmir,
  input  logic              vmir,
  input  logic              enlarge,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              pixel_ok,
  output logic              wrap
);

  localparam int OFF_W = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H);

  logic                  frame_start;
  logic [1:0]            mode_sh_reg;
  logic                  hmir_sh_reg;
  logic                  vmir_sh_reg;
  logic                  enl_sh_reg;
  logic [1:0][OFF_W-1:0] off_cur;    // [0] = x offset, [1] = y offset
  logic [1:0]            axis_wrap;

  assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // Capture mode controls once per frame, at the first pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_sh_reg <= 2'b00;
      hmir_sh_reg <= 1'b0;
      vmir_sh_reg <= 1'b0;
      enl_sh_reg  <= 1'b0;
    end else if (frame_start) begin
      mode_sh_reg <= mode;
      hmir_sh_reg <= hmir;
      vmir_sh_reg <= vmir;
      enl_sh_reg  <= enlarge;
    end
  end

  // One offset engine per axis: gi=0 is X (mode[1]), gi=1 is Y (mode[0]).
  // The tick uses the shadow mode, so a tick coinciding with frame start
  // still sees the previous frame's axis selection.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int             LIMIT  = (gi == 0) ? IMG_W : IMG_H;
      localparam logic [OFF_W:0] LIM_W  = (OFF_W+1)'(LIMIT);
      localparam logic [OFF_W:0] LIM_M1 = (OFF_W+1)'(LIMIT - 1);
      localparam logic [OFF_W:0] STEP_W = (OFF_W+1)'(STEP);

      logic [OFF_W-1:0] off_reg;
      logic [OFF_W-1:0] off_next;
      logic [OFF_W:0]   off_ext;
      logic [OFF_W:0]   inc;
      logic             adv;
      logic             wrap_next;
`ifdef BOUNCE_EN
      logic             flag_reg;
      logic             flag_next;
      logic             eff_dir;
`endif

      assign adv     = tick && en && mode_sh_reg[1-gi];
      assign off_ext = {1'b0, off_reg};
      assign inc     = off_ext + STEP_W;

      // Next offset: step, then fold back into [0, LIMIT-1]
      always_comb begin
        off_next  = off_reg;
        wrap_next = 1'b0;
`ifdef BOUNCE_EN
        flag_next = flag_reg;
        eff_dir   = dir ^ flag_reg;
        if (adv) begin
          if (!eff_dir) begin
            if (inc > LIM_M1) begin
              off_next  = LIM_M1[OFF_W-1:0];
              flag_next = ~flag_reg;
              wrap_next = 1'b1;
            end else begin
              off_next = inc[OFF_W-1:0];
            end
          end else begin
            if (off_ext < STEP_W) begin
              off_next  = '0;
              flag_next = ~flag_reg;
              wrap_next = 1'b1;
            end else begin
              off_next = OFF_W'(off_ext - STEP_W);
            end
          end
        end
`else
        if (adv) begin
          if (!dir) begin
            if (inc >= LIM_W) begin
              off_next  = OFF_W'(inc - LIM_W);
              wrap_next = 1'b1;
            end else begin
              off_next = inc[OFF_W-1:0];
            end
          end else begin
            if (off_ext < STEP_W) begin
              off_next  = OFF_W'(off_ext + LIM_W - STEP_W);
              wrap_next = 1'b1;
            end else begin
              off_next = OFF_W'(off_ext - STEP_W);
            end
          end
        end
`endif
      end

      // Offset state register
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          off_reg  <= '0;
`ifdef BOUNCE_EN
          flag_reg <= 1'b0;
`endif
        end else begin
          off_reg  <= off_next;
`ifdef BOUNCE_EN
          flag_reg <= flag_next;
`endif
        end
      end

      assign off_cur[gi]   = off_reg;
      assign axis_wrap[gi] = wrap_next;
    end
  endgenerate

  logic              eff_hmir;
  logic              eff_vmir;
  logic              eff_enl;
  logic              in_img;
  logic [31:0]       sx;
  logic [31:0]       sy;
  logic [31:0]       mx;
  logic [31:0]       my;
  logic [31:0]       u;
  logic [31:0]       w;
  logic [ADDR_W-1:0] addr_next;

  // Screen -> image coordinate mapping; the frame's first pixel already
  // uses the controls being latched on that cycle.
  always_comb begin
    eff_hmir = frame_start ? hmir    : hmir_sh_reg;
    eff_vmir = frame_start ? vmir    : vmir_sh_reg;
    eff_enl  = frame_start ? enlarge : enl_sh_reg;
    if (eff_enl) begin
      sx = (32'(h_cnt) >> (SCALE_SHIFT + 1)) + 32'(IMG_W / 4);
      sy = (32'(v_cnt) >> (SCALE_SHIFT + 1)) + 32'(IMG_H / 4);
    end else begin
      sx = 32'(h_cnt) >> SCALE_SHIFT;
      sy = 32'(v_cnt) >> SCALE_SHIFT;
    end
    in_img = valid && (sx < 32'(IMG_W)) && (sy < 32'(IMG_H));
    mx = eff_hmir ? (32'(IMG_W - 1) - sx) : sx;
    my = eff_vmir ? (32'(IMG_H - 1) - sy) : sy;
    u  = mx + 32'(off_cur[0]);
    if (u >= 32'(IMG_W)) u = u - 32'(IMG_W);
    w  = my + 32'(off_cur[1]);
    if (w >= 32'(IMG_H)) w = w - 32'(IMG_H);
    addr_next = in_img ? ADDR_W'(w * 32'(IMG_W) + u) : '0;
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_addr <= '0;
      pixel_ok   <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      pixel_addr <= addr_next;
      pixel_ok   <= in_img;
      wrap       <= |axis_wrap;
    end
  end

endmodule
